// File: rtl/npi_ict_rd_mp.sv
// Read-return router: pops NPI read data and pushes each beat tagged with its
// destination port and a last-beat flag, driven by a queue of {len,port} requests.
module npi_ict_rd_mp #(
    parameter int C_PIM_DATA_WIDTH = 64,
    parameter int C_NUM_PORTS      = 8,
    parameter int C_ID_WIDTH       = 3,
    parameter int C_LEN_WIDTH      = 6,
    parameter int C_STS_AWIDTH     = 4
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic [C_PIM_DATA_WIDTH-1:0] PIM_RdFIFO_Data,
    input  logic                        PIM_RdFIFO_Empty,
    input  logic [1:0]                  PIM_RdFIFO_Latency,
    output logic                        PIM_RdFIFO_Pop,
    output logic                        PIM_RdFIFO_Flush,
    input  logic                        rdsts_wren,
    input  logic [C_LEN_WIDTH-1:0]      rdsts_len,
    input  logic [C_ID_WIDTH-1:0]       rdsts_nr,
    output logic                        rdsts_afull,
    output logic                        rdsts_ovf,
    input  logic [C_NUM_PORTS-1:0]      port_afull,
    output logic                        PIM_RdFIFO_Push,
    output logic [C_PIM_DATA_WIDTH-1:0] PIM_RdFIFO_Push_Data,
    output logic [C_ID_WIDTH-1:0]       PIM_RdFIFO_Push_sel,
    output logic                        PIM_RdFIFO_Push_last,
    output logic [15:0]                 npi_ict_dbg
);

    localparam int DW    = C_PIM_DATA_WIDTH;
    localparam int IW    = C_ID_WIDTH;
    localparam int LW    = C_LEN_WIDTH;
    localparam int AW    = C_STS_AWIDTH;
    localparam int SW    = LW + IW;
    localparam int CW    = LW + 1;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     len_q, len_d;
    logic [IW-1:0]     port_q, port_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [3:0]        vld_q, vld_d;
    logic [3:0]        last_q, last_d;
    logic [3:0][IW-1:0] id_q, id_d;
    logic [DW-1:0]     data_q, data_d;
    logic [SW-1:0]     mem_q [DEPTH];

    logic [SW-1:0]     head, nxt;
    logic [IW-1:0]     bp_port;
    logic              full, pop, last_beat, rden, wr_acc, cap;
    logic [7:0]        dout;

    // A zero length field means a full 2**LW-beat burst.
    function automatic logic [CW-1:0] len_ext(input logic [LW-1:0] l);
        return (l == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, l};
    endfunction

    always_comb begin
        head      = mem_q[rd_ptr_q];
        nxt       = mem_q[rd_ptr_q + AW'(1)];
        full      = (cnt_q == (AW+1)'(DEPTH));
        bp_port   = ({1'b0, port_q} < (IW+1)'(C_NUM_PORTS)) ? port_q : '0;
        pop       = (state_q == S_DATA) && !PIM_RdFIFO_Empty && !port_afull[bp_port];
        last_beat = pop && (len_q == CW'(1));
        rden      = last_beat;
        wr_acc    = rdsts_wren && (!full || rden);
        dout      = 8'(head);
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        port_d   = port_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + (AW+1)'(wr_acc) - (AW+1)'(rden);
        ovf_d    = ovf_q || (rdsts_wren && full && !rden);
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rden)   rd_ptr_d = rd_ptr_q + AW'(1);

        case (state_q)
            S_IDLE: if (cnt_q != '0) state_d = S_LOAD;
            S_LOAD: begin
                len_d   = len_ext(head[SW-1:IW]);
                port_d  = head[IW-1:0];
                state_d = S_DATA;
            end
            S_DATA: begin
                if (last_beat) begin
                    // Chain straight into the next queued burst to avoid a bubble.
                    if (cnt_q > (AW+1)'(1)) begin
                        len_d  = len_ext(nxt[SW-1:IW]);
                        port_d = nxt[IW-1:0];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (pop) begin
                    len_d = len_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        vld_d  = {vld_q[2:0], pop};
        last_d = {last_q[2:0], last_beat};
        id_d   = {id_q[2:0], port_q};
        // NPI data for a pop at t is valid at t+L; capture it then.
        cap    = (PIM_RdFIFO_Latency == 2'd0) ? pop : vld_q[PIM_RdFIFO_Latency - 2'd1];
        data_d = cap ? PIM_RdFIFO_Data : data_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            port_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            vld_q    <= '0;
            last_q   <= '0;
            id_q     <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            port_q   <= port_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
            id_q     <= id_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= {rdsts_len, rdsts_nr};
    end

    assign PIM_RdFIFO_Pop       = pop;
    assign PIM_RdFIFO_Flush     = 1'b0;
    assign rdsts_afull          = (cnt_q >= (AW+1)'(DEPTH - 2));
    assign rdsts_ovf            = ovf_q;
    assign PIM_RdFIFO_Push      = vld_q[PIM_RdFIFO_Latency];
    assign PIM_RdFIFO_Push_Data = data_q;
    assign PIM_RdFIFO_Push_sel  = id_q[PIM_RdFIFO_Latency];
    assign PIM_RdFIFO_Push_last = last_q[PIM_RdFIFO_Latency];
    assign npi_ict_dbg          = {dout, wr_acc, rdsts_afull, rden, (cnt_q == '0), 2'b00, state_q};

endmodule

// File: tb/tb_npi_ict_rd_mp.sv
// Directed bench for npi_ict_rd_mp: records pop/push events with cycle stamps
// and checks them against hand-computed expectations.
module tb_npi_ict_rd_mp;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [63:0] PIM_RdFIFO_Data;
    logic        PIM_RdFIFO_Empty;
    logic [1:0]  PIM_RdFIFO_Latency;
    logic        PIM_RdFIFO_Pop, PIM_RdFIFO_Flush;
    logic        rdsts_wren;
    logic [5:0]  rdsts_len;
    logic [2:0]  rdsts_nr;
    logic        rdsts_afull, rdsts_ovf;
    logic [7:0]  port_afull;
    logic        PIM_RdFIFO_Push;
    logic [63:0] PIM_RdFIFO_Push_Data;
    logic [2:0]  PIM_RdFIFO_Push_sel;
    logic        PIM_RdFIFO_Push_last;
    logic [15:0] npi_ict_dbg;

    npi_ict_rd_mp dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .PIM_RdFIFO_Data(PIM_RdFIFO_Data), .PIM_RdFIFO_Empty(PIM_RdFIFO_Empty),
        .PIM_RdFIFO_Latency(PIM_RdFIFO_Latency), .PIM_RdFIFO_Pop(PIM_RdFIFO_Pop),
        .PIM_RdFIFO_Flush(PIM_RdFIFO_Flush), .rdsts_wren(rdsts_wren),
        .rdsts_len(rdsts_len), .rdsts_nr(rdsts_nr), .rdsts_afull(rdsts_afull),
        .rdsts_ovf(rdsts_ovf), .port_afull(port_afull), .PIM_RdFIFO_Push(PIM_RdFIFO_Push),
        .PIM_RdFIFO_Push_Data(PIM_RdFIFO_Push_Data), .PIM_RdFIFO_Push_sel(PIM_RdFIFO_Push_sel),
        .PIM_RdFIFO_Push_last(PIM_RdFIFO_Push_last), .npi_ict_dbg(npi_ict_dbg)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // NPI read FIFO model: sequential data words, returned L cycles after the pop.
    logic [63:0] src = 64'h100;
    logic [63:0] dl [3];
    always @(posedge Clk) begin
        if (PIM_RdFIFO_Pop) src <= src + 64'd1;
        dl[0] <= PIM_RdFIFO_Pop ? src : 64'd0;
        dl[1] <= dl[0];
        dl[2] <= dl[1];
    end
    always_comb PIM_RdFIFO_Data = (PIM_RdFIFO_Latency == 2'd0) ? src : dl[PIM_RdFIFO_Latency - 2'd1];

    typedef struct {
        int          cyc;
        logic [63:0] d;
        logic [2:0]  sel;
        logic        last;
    } ev_t;
    int  pop_q[$];
    ev_t push_q[$];

    always @(negedge Clk) begin
        if (PIM_RdFIFO_Pop === 1'b1) pop_q.push_back(cyc);
        if (PIM_RdFIFO_Push === 1'b1)
            push_q.push_back('{cyc, PIM_RdFIFO_Push_Data, PIM_RdFIFO_Push_sel, PIM_RdFIFO_Push_last});
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [5:0] len, input logic [2:0] nr);
        @(negedge Clk);
        rdsts_wren = 1'b1;
        rdsts_len  = len;
        rdsts_nr   = nr;
        @(negedge Clk);
        rdsts_wren = 1'b0;
    endtask

    int          pb, ub;
    logic [63:0] sb;

    initial begin
        Rst_n = 1'b0;
        PIM_RdFIFO_Empty = 1'b0;
        PIM_RdFIFO_Latency = 2'd1;
        rdsts_wren = 1'b0;
        rdsts_len = '0;
        rdsts_nr = '0;
        port_afull = '0;
        repeat (3) @(negedge Clk);
        chk("rst_pop", PIM_RdFIFO_Pop, 1'b0);
        chk("rst_push", PIM_RdFIFO_Push, 1'b0);
        chk("rst_ovf", rdsts_ovf, 1'b0);
        chk("rst_afull", rdsts_afull, 1'b0);
        chk("rst_state", npi_ict_dbg[3:0], 4'd0);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        chk("flush", PIM_RdFIFO_Flush, 1'b0);

        // Single burst of 4 to port 2, L=1.
        pb = pop_q.size(); ub = push_q.size(); sb = src;
        wr(6'd4, 3'd2);
        repeat (20) @(negedge Clk);
        chk("t1_npop", pop_q.size() - pb, 4);
        chk("t1_npush", push_q.size() - ub, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_popcyc%0d", i), pop_q[pb+i] - pop_q[pb], i);
            chk($sformatf("t1_lat%0d", i), push_q[ub+i].cyc - pop_q[pb+i], 2);
            chk($sformatf("t1_sel%0d", i), push_q[ub+i].sel, 3'd2);
            chk($sformatf("t1_last%0d", i), push_q[ub+i].last, (i == 3));
            chk($sformatf("t1_data%0d", i), push_q[ub+i].d, sb + i);
        end

        // Back-to-back bursts {3,1},{2,5}.
        pb = pop_q.size(); ub = push_q.size(); sb = src;
        wr(6'd3, 3'd1);
        wr(6'd2, 3'd5);
        repeat (20) @(negedge Clk);
        chk("t2_npop", pop_q.size() - pb, 5);
        chk("t2_npush", push_q.size() - ub, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_popcyc%0d", i), pop_q[pb+i] - pop_q[pb], i);
            chk($sformatf("t2_sel%0d", i), push_q[ub+i].sel, (i < 3) ? 3'd1 : 3'd5);
            chk($sformatf("t2_last%0d", i), push_q[ub+i].last, (i == 2 || i == 4));
            chk($sformatf("t2_data%0d", i), push_q[ub+i].d, sb + i);
        end

        // Latency 0 and 3.
        for (int l = 0; l < 4; l += 3) begin
            PIM_RdFIFO_Latency = 2'(l);
            pb = pop_q.size(); ub = push_q.size(); sb = src;
            wr(6'd2, 3'd6);
            repeat (20) @(negedge Clk);
            chk($sformatf("t3_L%0d_npush", l), push_q.size() - ub, 2);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("t3_L%0d_lat%0d", l, i), push_q[ub+i].cyc - pop_q[pb+i], l + 1);
                chk($sformatf("t3_L%0d_data%0d", l, i), push_q[ub+i].d, sb + i);
            end
        end
        PIM_RdFIFO_Latency = 2'd1;

        // Backpressure on port 2 during beats 2-4.
        pb = pop_q.size(); ub = push_q.size(); sb = src;
        wr(6'd4, 3'd2);
        for (int i = 0; i < 20 && PIM_RdFIFO_Pop !== 1'b1; i++) @(negedge Clk);
        chk("t4_first_pop", PIM_RdFIFO_Pop, 1'b1);
        @(posedge Clk); #1 port_afull = 8'b0000_0100;
        repeat (3) @(posedge Clk);
        #1 port_afull = '0;
        repeat (20) @(negedge Clk);
        chk("t4_npop", pop_q.size() - pb, 4);
        chk("t4_npush", push_q.size() - ub, 4);
        chk("t4_gap", pop_q[pb+1] - pop_q[pb], 4);
        chk("t4_tail", pop_q[pb+3] - pop_q[pb], 6);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t4_data%0d", i), push_q[ub+i].d, sb + i);
        chk("t4_last", push_q[ub+3].last, 1'b1);

        // Status FIFO fill and overflow with no reads.
        PIM_RdFIFO_Empty = 1'b1;
        pb = pop_q.size(); ub = push_q.size();
        for (int k = 1; k <= 17; k++) begin
            wr(6'd1, 3'(k - 1));
            if (k == 13) chk("t5_afull13", rdsts_afull, 1'b0);
            if (k == 14) chk("t5_afull14", rdsts_afull, 1'b1);
            if (k == 16) chk("t5_ovf16", rdsts_ovf, 1'b0);
            if (k == 17) chk("t5_ovf17", rdsts_ovf, 1'b1);
        end
        chk("t5_nopop", pop_q.size() - pb, 0);
        PIM_RdFIFO_Empty = 1'b0;
        repeat (40) @(negedge Clk);
        chk("t5_npop", pop_q.size() - pb, 16);
        chk("t5_npush", push_q.size() - ub, 16);
        chk("t5_span", pop_q[pb+15] - pop_q[pb], 15);
        chk("t5_sel15", push_q[ub+15].sel, 3'd7);
        chk("t5_sel9", push_q[ub+9].sel, 3'd1);
        chk("t5_afull_drained", rdsts_afull, 1'b0);
        chk("t5_ovf_sticky", rdsts_ovf, 1'b1);

        // Reset mid-burst.
        wr(6'd8, 3'd3);
        for (int i = 0; i < 20 && PIM_RdFIFO_Pop !== 1'b1; i++) @(negedge Clk);
        chk("t6_popseen", PIM_RdFIFO_Pop, 1'b1);
        repeat (2) @(negedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        chk("t6_pop", PIM_RdFIFO_Pop, 1'b0);
        chk("t6_push", PIM_RdFIFO_Push, 1'b0);
        chk("t6_ovf", rdsts_ovf, 1'b0);
        chk("t6_state", npi_ict_dbg[3:0], 4'd0);
        pb = pop_q.size(); ub = push_q.size();
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (12) @(negedge Clk);
        chk("t6_nopop", pop_q.size() - pb, 0);
        chk("t6_nostale", push_q.size() - ub, 0);
        chk("t6_idle", npi_ict_dbg[3:0], 4'd0);
        chk("t6_empty", npi_ict_dbg[4], 1'b1);
        chk("t6_ovf_after", rdsts_ovf, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
